// File: rtl/ram16x8_loader_if.sv
// Byte-stream load port plus combinational read port of the 16x8 loader RAM.
// The master drives the stream and the read address; the slave is the loader.
interface ram16x8_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;

    modport master (
        output start, base_addr, in_valid, in_data, in_last, addr,
        input  in_ready, data_out, busy, done, wr_count
    );

    modport slave (
        input  start, base_addr, in_valid, in_data, in_last, addr,
        output in_ready, data_out, busy, done, wr_count
    );
endinterface

// File: rtl/ram16x8_loader.sv
// Register-file RAM loaded from a valid/ready byte stream at auto-incrementing
// addresses, with a combinational addr -> data_out read port.
module ram16x8_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    ram16x8_loader_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   wr_count;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
        return (c == CNT_MAX) ? c : c + (ADDR_W + 1)'(1);
    endfunction

    assign accept = bus.in_valid && (state == S_LOAD);

    // The DEPTH-th accepted byte closes the session whether or not in_last is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        wr_ptr   <= bus.base_addr;
                        wr_count <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        wr_count <= sat_inc(wr_count);
                        if (bus.in_last || wr_count == LAST_CNT)
                            state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst)
                mem[i] <= '0;
            else if (accept && wr_ptr == ADDR_W'(i))
                mem[i] <= bus.in_data;
        end
    end

    assign bus.in_ready = (state == S_LOAD);
    assign bus.busy     = (state == S_LOAD);
    assign bus.done     = (state == S_DONE);
    assign bus.wr_count = wr_count;
    assign bus.data_out = mem[bus.addr];
endmodule

// File: tb/tb_ram16x8_loader.sv
// Randomized scoreboard bench for ram16x8_loader: a session-level memory model
// predicts table contents and session byte counts; a monitor checks them.
module tb_ram16x8_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram16x8_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram16x8_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [16];
    int         exp_done_q [$];
    logic [7:0] rd_q [$];
    logic [3:0] rd_addr_q [$];
    bit         rd_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: read-port samples and session completions, popped as they appear.
    always @(negedge clk) begin
        if (rd_req) begin
            if (rd_q.size() == 0) begin
                check("read_queue_underflow", 1, 0);
            end else begin
                logic [7:0] e;
                logic [3:0] a;
                e = rd_q.pop_front();
                a = rd_addr_q.pop_front();
                check($sformatf("data_out[%0d]", a), bus.data_out, e);
            end
        end
        if (bus.done === 1'b1) begin
            if (exp_done_q.size() == 0)
                check("unexpected_done", 1, 0);
            else
                check("wr_count_at_done", bus.wr_count, exp_done_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_sweep();
        for (int a = 0; a < 16; a++) begin
            bus.addr = 4'(a);
            rd_q.push_back(ref_mem[a]);
            rd_addr_q.push_back(4'(a));
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
        end
    endtask

    // Present one byte with random idle gaps and hold it until handshaked.
    task automatic send(input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        bit rdy;
        repeat ($urandom_range(0, 2)) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int b = 0; b < 50 && !ok; b++) begin
            rdy = bus.in_ready;
            tick();
            ok = rdy;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!ok) check("handshake_timeout", 0, 1);
    endtask

    task automatic session(input logic [3:0] base, input int n, input bit use_last,
                           input bit mid_start, input logic [7:0] first,
                           input logic [7:0] step, input bit rand_data);
        int cnt = 0;
        logic [7:0] d;
        bit last;
        bus.start     = 1'b1;
        bus.base_addr = base;
        tick();
        bus.start = 1'b0;
        check("in_ready_in_load", bus.in_ready, 1);
        check("busy_in_load", bus.busy, 1);
        for (int i = 0; i < n && cnt < 16; i++) begin
            if (mid_start && i == 1) begin
                bus.start     = 1'b1;
                bus.base_addr = 4'($urandom);
                tick();
                bus.start = 1'b0;
            end
            d    = rand_data ? 8'($urandom) : 8'(first + step * i);
            last = use_last && (i == n - 1);
            send(d, last);
            ref_mem[(base + cnt) % 16] = d;
            cnt++;
            if (last) break;
        end
        exp_done_q.push_back(cnt);
        check("done_after_final_accept", bus.done, 1);
        check("in_ready_low_in_done", bus.in_ready, 0);
        tick();
        check("done_single_pulse", bus.done, 0);
        check("in_ready_low_after", bus.in_ready, 0);
        if (!use_last) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hEE;
            for (int k = 0; k < 3; k++) begin
                check("no_accept_after_cap", bus.in_ready, 0);
                tick();
            end
            bus.in_valid = 1'b0;
        end
        check("wr_count_held", bus.wr_count, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.addr      = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_wr_count", bus.wr_count, 0);
        read_sweep();

        session(4'd0, 4, 1'b1, 1'b0, 8'hA0, 8'h01, 1'b0);
        read_sweep();
        session(4'd14, 3, 1'b1, 1'b0, 8'h11, 8'h11, 1'b0);
        read_sweep();
        session(4'd0, 16, 1'b0, 1'b0, 8'h10, 8'h01, 1'b0);
        read_sweep();
        session(4'd6, 7, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
        read_sweep();

        for (int s = 0; s < 6; s++) begin
            bit ul;
            ul = 1'($urandom);
            session(4'($urandom), ul ? int'($urandom_range(1, 16)) : 16, ul,
                    1'($urandom), 8'h00, 8'h00, 1'b1);
            read_sweep();
        end

        // Abort a session after two bytes: memory clears, no done pulse.
        bus.start     = 1'b1;
        bus.base_addr = 4'd5;
        tick();
        bus.start = 1'b0;
        send(8'h5A, 1'b0);
        send(8'hA5, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_wr_count", bus.wr_count, 0);
        repeat (3) begin
            check("abort_no_done", bus.done, 0);
            tick();
        end
        read_sweep();

        repeat (3) tick();
        check("done_queue_drained", exp_done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
